// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
// clk_period_meter: synchronises a slow asynchronous square wave into the clk
// domain. It measures the rise-to-rise period and the high time in clk cycles,
// and reports lock and timeout status.
module clk_period_meter #(
    parameter int CNT_W       = 28,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout
);

    localparam int STAB_W = $clog2(LOCK_CNT + 1);
    // Last count value before timeout: 2^CNT_W-2, which is all ones except the LSB
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic {
        ST_WAIT,
        ST_MEAS
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     prev_q, prev_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         hcnt_q, hcnt_d;
    logic [CNT_W-1:0]         period_q, period_d;
    logic [CNT_W-1:0]         high_q, high_d;
    logic [CNT_W-1:0]         prev_period_q, prev_period_d;
    logic [STAB_W-1:0]        stab_q, stab_d;
    logic                     first_q, first_d;
    logic                     vld_q, vld_d;
    logic                     locked_q, locked_d;
    logic                     timeout_q, timeout_d;

    logic                     s;
    logic                     rise;
    logic [CNT_W-1:0]         new_period;
    logic [CNT_W-1:0]         diff;

    assign s          = sync_q[SYNC_STAGES-1];
    assign rise       = s & ~prev_q;
    assign new_period = cnt_q + CNT_W'(1);
    assign diff       = (new_period >= prev_period_q) ? (new_period - prev_period_q)
                                                      : (prev_period_q - new_period);

    // Synchroniser shift and edge-detect history; these flops ignore clr
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = s;
    end

    // Measurement FSM: next state, counters, results and status
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hcnt_d        = hcnt_q;
        period_d      = period_q;
        high_d        = high_q;
        prev_period_d = prev_period_q;
        stab_d        = stab_q;
        first_d       = first_q;
        vld_d         = 1'b0;
        locked_d      = locked_q;
        timeout_d     = timeout_q;

        if (clr) begin
            state_d   = ST_WAIT;
            cnt_d     = '0;
            hcnt_d    = '0;
            stab_d    = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (rise) begin
                        state_d = ST_MEAS;
                        cnt_d   = '0;
                        // s is high in the rise cycle, which belongs to the new interval
                        hcnt_d  = CNT_W'(1);
                        first_d = 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_d      = new_period;
                        high_d        = hcnt_q;
                        vld_d         = 1'b1;
                        timeout_d     = 1'b0;
                        cnt_d         = '0;
                        hcnt_d        = CNT_W'(1);
                        first_d       = 1'b0;
                        prev_period_d = new_period;
                        if (first_q) begin
                            stab_d = '0;
                        end else if (diff <= CNT_W'(TOL)) begin
                            stab_d = (stab_q == STAB_W'(LOCK_CNT)) ? stab_q : stab_q + STAB_W'(1);
                        end else begin
                            stab_d = '0;
                        end
                        locked_d = (stab_d >= STAB_W'(LOCK_CNT));
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_WAIT;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        stab_d    = '0;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        hcnt_d = hcnt_q + CNT_W'(s);
                    end
                end
                default: state_d = ST_WAIT;
            endcase
        end
    end

    // State and data registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_WAIT;
            sync_q        <= '0;
            prev_q        <= 1'b0;
            cnt_q         <= '0;
            hcnt_q        <= '0;
            period_q      <= '0;
            high_q        <= '0;
            prev_period_q <= '0;
            stab_q        <= '0;
            first_q       <= 1'b0;
            vld_q         <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            hcnt_q        <= hcnt_d;
            period_q      <= period_d;
            high_q        <= high_d;
            prev_period_q <= prev_period_d;
            stab_q        <= stab_d;
            first_q       <= first_d;
            vld_q         <= vld_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule
